// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: opcode constants, instruction format enum,
// opcode-to-format mapping and the opcode legality check.
// Purely declarative; no state.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_LHU      = 6'b100101;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    // Anything not explicitly R or J falls back to the I-type layout.
    function automatic fmt_e op_fmt(input logic [5:0] op);
        fmt_e f;
        case (op)
            OP_RTYPE, OP_SPECIAL2: f = FMT_R;
            OP_J, OP_JAL:          f = FMT_J;
            default:               f = FMT_I;
        endcase
        return f;
    endfunction

    // Opcodes 000000..001111 are all legal, plus a sparse set of loads/stores.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_SPECIAL2, OP_LB, OP_LH, OP_LW, OP_LBU,
            OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:                     ok = (op[5:4] == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Packs decoded instruction fields into a 32-bit MIPS word according to opcode format.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mips_word_pack
    import mips_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o
);

    // Select the bit layout from the opcode's format class.
    always_comb begin
        word_o = {op_i, rs_i, rt_i, imm_i};
        case (op_fmt(op_i))
            FMT_R:   word_o = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
            FMT_J:   word_o = {op_i, target_i};
            default: word_o = {op_i, rs_i, rt_i, imm_i};
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams field beats into encoded MIPS words written sequentially to instruction memory.
// Latency: one cycle from accepted beat to write strobe; one word per cycle throughput.
// Backpressure: in_ready_o low outside RUN and in an abort cycle. MIPS_ENC_OPCHECK_EN drops illegal opcodes.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [5:0]        op_i,
    input  logic [5:0]        funct_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-2:0] word_count_o,
    output logic              illegal_op_o,
    output logic              wrapped_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-2:0] WC_ONE    = (ADDR_W-1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-2:0]   wc_q;
    logic                wrapped_q;
    logic                we_q;
    logic [ADDR_W-1:0]   oaddr_q;
    logic [31:0]         odata_q;
    logic                done_q;
    logic [31:0]         word;
    logic                op_legal;
    logic                accept;
    logic                wr_fire;
    logic                load_start;

    mips_word_pack u_pack (
        .op_i     (op_i),
        .funct_i  (funct_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .rd_i     (rd_i),
        .shamt_i  (shamt_i),
        .imm_i    (imm_i),
        .target_i (target_i),
        .word_o   (word)
    );

`ifdef MIPS_ENC_OPCHECK_EN
    assign op_legal = op_is_legal(op_i);
`else
    assign op_legal = 1'b1;
`endif

    assign accept     = in_valid_i && in_ready_o;
    assign wr_fire    = accept && op_legal;
    assign load_start = (state_q == ST_IDLE) && start_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state: Start opens a load; Abort or the last accepted beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (abort_i || (accept && in_last_i)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: Abort masks ready so a same-cycle beat is never taken.
    always_comb begin
        busy_o     = (state_q == ST_RUN);
        in_ready_o = (state_q == ST_RUN) && !abort_i;
    end

    // Write address, word count and wrap flag; Start is only honoured from IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wc_q      <= '0;
            wrapped_q <= 1'b0;
        end else if (load_start) begin
            addr_q    <= base_addr_i & ~ADDR_W'(3);
            wc_q      <= '0;
            wrapped_q <= 1'b0;
        end else if (wr_fire) begin
            addr_q <= addr_q + ADDR_STEP;
            if (addr_q == ADDR_LAST) wrapped_q <= 1'b1;
            if (wc_q != '1)          wc_q      <= wc_q + WC_ONE;
        end
    end

    // Output stage: one registered write per accepted legal beat, plus the Done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= wr_fire;
            done_q <= accept && in_last_i;
            if (wr_fire) begin
                oaddr_q <= addr_q;
                odata_q <= word;
            end
        end
    end

`ifdef MIPS_ENC_OPCHECK_EN
    logic illegal_q;

    // Sticky record of any dropped illegal beat since the last Start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   illegal_q <= 1'b0;
        else if (load_start)           illegal_q <= 1'b0;
        else if (accept && !op_legal)  illegal_q <= 1'b1;
    end

    assign illegal_op_o = illegal_q;
`else
    assign illegal_op_o = 1'b0;
`endif

    assign imem_we_o    = we_q;
    assign imem_addr_o  = oaddr_q;
    assign imem_data_o  = odata_q;
    assign done_o       = done_q;
    assign word_count_o = wc_q;
    assign wrapped_o    = wrapped_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed beats push expected writes,
// a negedge monitor pops and compares every write/done event.
// Status checks (busy, counts, flags) are made directly from the stimulus thread.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 10;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] word_count;
    logic              illegal_op;
    logic              wrapped;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .abort_i      (abort),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_last_i    (in_last),
        .op_i         (op),
        .funct_i      (funct),
        .rs_i         (rs),
        .rt_i         (rt),
        .rd_i         (rd),
        .shamt_i      (shamt),
        .imm_i        (imm),
        .target_i     (target),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .busy_o       (busy),
        .done_o       (done),
        .word_count_o (word_count),
        .illegal_op_o (illegal_op),
        .wrapped_o    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [31:0] d, input logic dn);
        exp_t e;
        e.we = 1'b1; e.addr = a; e.data = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic expect_done_only();
        exp_t e;
        e.we = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a write or a Done pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (imem_we || done)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: we=%0b addr=0x%03h data=0x%08h done=%0b, expected none",
                         imem_we, imem_addr, imem_data, done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (imem_we !== e.we || done !== e.done ||
                    (e.we && (imem_addr !== e.addr || imem_data !== e.data))) begin
                    n_err++;
                    $display("FAIL write: got we=%0b addr=0x%03h data=0x%08h done=%0b, expected we=%0b addr=0x%03h data=0x%08h done=%0b",
                             imem_we, imem_addr, imem_data, done, e.we, e.addr, e.data, e.done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [9:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    // Present one beat (DUT is expected to be ready) and hold it for one edge.
    task automatic beat(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] tg, input logic lst);
        op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
        in_last = lst;
        in_valid = 1'b1;
        #1;
        chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"},       {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"},     {22'd0, imem_addr}, 32'd0);
        chk({tag, "_data"},     imem_data, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, done}, 32'd0);
        chk({tag, "_wc"},       {23'd0, word_count}, 32'd0);
        chk({tag, "_illegal"},  {31'd0, illegal_op}, 32'd0);
        chk({tag, "_wrapped"},  {31'd0, wrapped}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; abort = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        op = '0; funct = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        #12;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // addi / add / j program at 0x040
        start_load(10'h040);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        expect_wr(10'h040, 32'h2022_0005, 1'b0);
        beat(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
        expect_wr(10'h044, 32'h0022_1820, 1'b0);
        beat(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0000, 26'd0, 1'b0);
        expect_wr(10'h048, 32'h0800_0010, 1'b1);
        beat(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h000_0010, 1'b1);
        chk("t1_wc", {23'd0, word_count}, 32'd3);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        tick();

        // Abort while a beat is presented: prior write completes, beat dropped
        start_load(10'h100);
        expect_wr(10'h100, 32'h3401_1234, 1'b0);
        beat(6'b001101, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
        op = 6'b001101; rt = 5'd2; imm = 16'h5678; in_valid = 1'b1; abort = 1'b1;
        #1;
        chk("t2_ready_abort", {31'd0, in_ready}, 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_wc", {23'd0, word_count}, 32'd1);
        tick();

        // Illegal opcode followed by sw
        start_load(10'h200);
`ifdef MIPS_ENC_OPCHECK_EN
        beat(6'b010000, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b0);
        expect_wr(10'h200, 32'hAFBF_FFFC, 1'b1);
        beat(6'b101011, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1);
        chk("t3_illegal", {31'd0, illegal_op}, 32'd1);
        chk("t3_wc", {23'd0, word_count}, 32'd1);
`else
        expect_wr(10'h200, 32'h4000_0000, 1'b0);
        beat(6'b010000, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b0);
        expect_wr(10'h204, 32'hAFBF_FFFC, 1'b1);
        beat(6'b101011, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1);
        chk("t3_illegal", {31'd0, illegal_op}, 32'd0);
        chk("t3_wc", {23'd0, word_count}, 32'd2);
`endif
        tick();

        // Address wrap from 0x3F8
        start_load(10'h3F8);
        chk("t4_illegal_cleared", {31'd0, illegal_op}, 32'd0);
        expect_wr(10'h3F8, 32'h3C01_0001, 1'b0);
        beat(6'b001111, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        chk("t4_wrapped_early", {31'd0, wrapped}, 32'd0);
        expect_wr(10'h3FC, 32'h3C02_0002, 1'b0);
        beat(6'b001111, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0);
        expect_wr(10'h000, 32'h3C03_0003, 1'b0);
        beat(6'b001111, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0);
        expect_wr(10'h004, 32'h3C04_0004, 1'b1);
        beat(6'b001111, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
        chk("t4_wrapped", {31'd0, wrapped}, 32'd1);
        chk("t4_wc", {23'd0, word_count}, 32'd4);
        tick();

        // Start while busy is ignored
        start_load(10'h080);
        chk("t5_wrapped_cleared", {31'd0, wrapped}, 32'd0);
        expect_wr(10'h080, 32'h2001_0001, 1'b0);
        beat(6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        start_load(10'h300);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_wc_kept", {23'd0, word_count}, 32'd1);
        expect_wr(10'h084, 32'h2002_0002, 1'b1);
        beat(6'b001000, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b1);
        chk("t5_wc", {23'd0, word_count}, 32'd2);
        tick();

        // Reset right after an accepting handshake drops the pending write
        start_load(10'h000);
        beat(6'b001000, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        repeat (3) tick();
        chk("drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
